// File: rtl/xorexec_pkg.sv
// Shared definitions for the xorexec output path: frame states and header field layout.
package xorexec_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PAY  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 3;

    // Header layout: low LEN_W bits carry the payload length, anything above must be zero.
    localparam logic [DATA_W_DEF-1:0] HDR_LEN_MASK   = DATA_W_DEF'((1 << LEN_W_DEF) - 1);
    localparam logic [DATA_W_DEF-1:0] HDR_UPPER_MASK = ~HDR_LEN_MASK;

    function automatic logic [LEN_W_DEF-1:0] hdr_len(input logic [DATA_W_DEF-1:0] hdr);
        return hdr[LEN_W_DEF-1:0];
    endfunction

    function automatic logic hdr_bad(input logic [DATA_W_DEF-1:0] hdr);
        return |(hdr & HDR_UPPER_MASK);
    endfunction

endpackage

// File: rtl/xorexec_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module xorexec_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/xorexec_frame_collector.sv
// Drains the xorexec output FIFO and re-frames it into length-prefixed transactions.
// Optional build macro XORC_TIMEOUT_EN abandons a payload after TIMEOUT idle cycles.
import xorexec_pkg::*;

module xorexec_frame_collector #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ofifo_rdy,
    input  logic [DATA_W-1:0] odata,
    output logic              ofifo_pop,
    output logic              frm_valid,
    input  logic              frm_ready,
    output logic [LEN_W-1:0]  frm_len,
    output logic [DATA_W-1:0] frm_xor,
    output logic              frm_err,
    output logic [CNT_W-1:0]  frm_cnt,
    output logic [7:0]        err_cnt
);

    state_t            state;
    logic [LEN_W-1:0]  rem;
    logic [LEN_W-1:0]  len_acc;
    logic [DATA_W-1:0] xor_acc;
    logic              hdr_err;

    logic [LEN_W-1:0]  hdr_len_f;
    logic              hdr_upper;
    logic              accept;

    assign hdr_len_f = odata[LEN_W-1:0];
    assign hdr_upper = |odata[DATA_W-1:LEN_W];

    // Reset gates the pop so nothing is consumed while the block is held in reset.
    assign ofifo_pop = rst_n & ofifo_rdy & ((state == HDR) | (state == PAY));
    assign frm_valid = (state == EMIT);
    assign accept    = frm_valid & frm_ready;

`ifdef XORC_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HDR;
            rem     <= '0;
            len_acc <= '0;
            xor_acc <= '0;
            hdr_err <= 1'b0;
            frm_len <= '0;
            frm_xor <= '0;
            frm_err <= 1'b0;
`ifdef XORC_TIMEOUT_EN
            idle    <= '0;
`endif
        end else begin
            case (state)
                HDR: begin
`ifdef XORC_TIMEOUT_EN
                    idle <= '0;
`endif
                    if (ofifo_pop) begin
                        rem     <= hdr_len_f;
                        xor_acc <= '0;
                        len_acc <= '0;
                        hdr_err <= hdr_upper;
                        if (hdr_len_f == '0) begin
                            frm_len <= '0;
                            frm_xor <= '0;
                            frm_err <= hdr_upper;
                            state   <= EMIT;
                        end else begin
                            state   <= PAY;
                        end
                    end
                end
                PAY: begin
                    if (ofifo_pop) begin
                        xor_acc <= xor_acc ^ odata;
                        len_acc <= len_acc + 1'b1;
                        rem     <= rem - 1'b1;
`ifdef XORC_TIMEOUT_EN
                        idle    <= '0;
`endif
                        // Descriptor fields are taken from the next-state values so EMIT sees the full frame.
                        if (rem == LEN_W'(1)) begin
                            frm_len <= len_acc + 1'b1;
                            frm_xor <= xor_acc ^ odata;
                            frm_err <= hdr_err;
                            state   <= EMIT;
                        end
                    end
`ifdef XORC_TIMEOUT_EN
                    else if (idle == IDLE_W'(TIMEOUT - 1)) begin
                        frm_len <= len_acc;
                        frm_xor <= xor_acc;
                        frm_err <= 1'b1;
                        idle    <= '0;
                        state   <= EMIT;
                    end else begin
                        idle <= idle + 1'b1;
                    end
`endif
                end
                EMIT: begin
                    if (frm_ready) begin
                        frm_len <= '0;
                        frm_xor <= '0;
                        frm_err <= 1'b0;
                        state   <= HDR;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

    xorexec_sat_counter #(.W(CNT_W)) u_frm_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .clear (1'b0),
        .cnt   (frm_cnt)
    );

    xorexec_sat_counter #(.W(8)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept & frm_err),
        .clear (1'b0),
        .cnt   (err_cnt)
    );

endmodule

// File: tb/tb_xorexec_frame_collector.sv
// Directed bench: a byte-queue FIFO model feeds the collector, expected descriptors are scoreboarded.
module tb_xorexec_frame_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ofifo_rdy;
    logic [7:0] odata;
    logic       ofifo_pop;
    logic       frm_valid;
    logic       frm_ready;
    logic [2:0] frm_len;
    logic [7:0] frm_xor;
    logic       frm_err;
    logic [15:0] frm_cnt;
    logic [7:0] err_cnt;

    typedef struct {
        logic [2:0] len;
        logic [7:0] x;
        logic       err;
    } desc_t;

    logic [7:0] bq[$];
    desc_t      eq[$];
    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int npops, nvalid, first_pop, last_pop, idle_seen;
    bit pop_seen, valid_seen;

    always #5 clk = ~clk;

    xorexec_frame_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ofifo_rdy (ofifo_rdy),
        .odata     (odata),
        .ofifo_pop (ofifo_pop),
        .frm_valid (frm_valid),
        .frm_ready (frm_ready),
        .frm_len   (frm_len),
        .frm_xor   (frm_xor),
        .frm_err   (frm_err),
        .frm_cnt   (frm_cnt),
        .err_cnt   (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        ofifo_rdy = (bq.size() != 0);
        odata     = (bq.size() != 0) ? bq[0] : 8'h00;
    endtask

    task automatic push_frame(input logic [7:0] bytes[$], input bit expect_it,
                              input logic [2:0] len, input logic [7:0] x, input logic err);
        desc_t d;
        foreach (bytes[i]) bq.push_back(bytes[i]);
        if (expect_it) begin
            d.len = len; d.x = x; d.err = err;
            eq.push_back(d);
        end
        drive();
    endtask

    // One clock: sample at negedge, scoreboard any handshake, then advance the FIFO model.
    task automatic cyc();
        desc_t d;
        @(negedge clk);
        cyc_n++;
        pop_seen   = ofifo_pop;
        valid_seen = frm_valid;
        if (ofifo_pop) begin
            npops++;
            if (first_pop < 0) first_pop = cyc_n;
            last_pop = cyc_n;
            if (!ofifo_rdy) check("pop_without_rdy", 1, 0);
        end
        if (frm_valid) nvalid++;
        if (frm_valid && frm_ready) begin
            if (eq.size() == 0) begin
                check("unexpected_descriptor", 1, 0);
            end else begin
                d = eq.pop_front();
                check("frm_len", frm_len, d.len);
                check("frm_xor", frm_xor, d.x);
                check("frm_err", frm_err, d.err);
            end
        end
        @(posedge clk);
        #1;
        if (pop_seen && bq.size() != 0) void'(bq.pop_front());
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((eq.size() != 0 || bq.size() != 0 || frm_valid) && n < budget) begin
            cyc();
            n++;
        end
        if (n >= budget) check("drain_timeout", 1, 0);
    endtask

    task automatic clear_stats();
        npops = 0; nvalid = 0; first_pop = -1; last_pop = -1;
    endtask

    initial begin
        rst_n = 1'b0; frm_ready = 1'b0; ofifo_rdy = 1'b0; odata = 8'h00;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", frm_valid, 0);
        check("rst_pop", ofifo_pop, 0);
        check("rst_frm_cnt", frm_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_len_xor_err", {frm_len, frm_xor, frm_err}, 0);
        rst_n = 1'b1;

        // Basic frame, back to back
        frm_ready = 1'b1;
        clear_stats();
        push_frame('{8'h03, 8'h11, 8'h22, 8'h44}, 1, 3'd3, 8'h77, 1'b0);
        drain(20);
        check("t1_pops", npops, 4);
        check("t1_pop_span", last_pop - first_pop, 3);
        check("t1_valid_cycles", nvalid, 1);
        check("t1_frm_cnt", frm_cnt, 1);

        // Empty frame then single-byte frame
        push_frame('{8'h00}, 1, 3'd0, 8'h00, 1'b0);
        push_frame('{8'h01, 8'hAB}, 1, 3'd1, 8'hAB, 1'b0);
        drain(20);
        check("t2_frm_cnt", frm_cnt, 3);

        // Back-pressure: descriptor holds and no pops while stalled
        frm_ready = 1'b0;
        push_frame('{8'h02, 8'h0F, 8'hF0}, 1, 3'd2, 8'hFF, 1'b0);
        push_frame('{8'h01, 8'h55}, 1, 3'd1, 8'h55, 1'b0);
        for (int i = 0; i < 10 && !frm_valid; i++) cyc();
        check("t3_valid_reached", frm_valid, 1);
        clear_stats();
        for (int i = 0; i < 20; i++) cyc();
        check("t3_pops_while_stalled", npops, 0);
        check("t3_valid_held", nvalid, 20);
        check("t3_len_xor_held", {frm_len, frm_xor}, {3'd2, 8'hFF});
        frm_ready = 1'b1;
        cyc();
        check("t3_no_pop_in_handshake", pop_seen, 0);
        cyc();
        check("t3_pop_resumes", pop_seen, 1);
        drain(20);
        check("t3_frm_cnt", frm_cnt, 5);

        // Malformed header
        push_frame('{8'hFA, 8'h01, 8'h02}, 1, 3'd2, 8'h03, 1'b1);
        drain(20);
        check("t4_err_cnt", err_cnt, 1);
        check("t4_frm_cnt", frm_cnt, 6);

        // Reset in the middle of a payload
        push_frame('{8'h05, 8'h66, 8'h77}, 0, 3'd0, 8'h00, 1'b0);
        for (int i = 0; i < 10 && bq.size() != 0; i++) cyc();
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_async_cnt", {frm_cnt, err_cnt}, 0);
        check("t5_async_outs", {frm_valid, ofifo_pop, frm_len, frm_xor, frm_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_frame('{8'h01, 8'h5A}, 1, 3'd1, 8'h5A, 1'b0);
        drain(20);
        check("t5_frm_cnt", frm_cnt, 1);
        check("t5_err_cnt", err_cnt, 0);

        // Long idle gap inside a payload
`ifdef XORC_TIMEOUT_EN
        push_frame('{8'h05, 8'h10, 8'h20}, 1, 3'd2, 8'h30, 1'b1);
`else
        push_frame('{8'h05, 8'h10, 8'h20}, 0, 3'd0, 8'h00, 1'b0);
`endif
        for (int i = 0; i < 10 && bq.size() != 0; i++) cyc();
        idle_seen = 0;
        clear_stats();
        for (int i = 0; i < 70; i++) begin
            cyc();
            if (nvalid == 0) idle_seen++;
        end
`ifdef XORC_TIMEOUT_EN
        check("t6_timeout_valid", nvalid, 1);
        check("t6_idle_before_emit", idle_seen, 64);
        check("t6_err_cnt", err_cnt, 1);
`else
        check("t6_no_valid_while_idle", nvalid, 0);
        push_frame('{8'h01, 8'h02, 8'h04}, 1, 3'd5, 8'h37, 1'b0);
        drain(20);
        check("t6_frm_cnt", frm_cnt, 2);
        check("t6_err_cnt", err_cnt, 0);
`endif
        check("scoreboard_empty", eq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
